// File: rtl/branch_stack.sv
// Branch checkpoint stack: one recovery checkpoint per in-flight branch, indexed by its
// one-hot mask bit. A mispredicted resolve drives restore data combinationally.
module branch_stack #(
  parameter int B_MASK_WIDTH     = 4,
  parameter int ROB_SZ_BITS      = 5,
  parameter int PHYS_REG_SZ_R10K = 64,
  parameter int ARCH_REG_SZ_R10K = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int PHYS_IDX_BITS    = $clog2(PHYS_REG_SZ_R10K)
) (
  input  logic                                           clock_i,
  input  logic                                           reset_i,
  input  logic [B_MASK_WIDTH-1:0]                        b_mm_resolve_i,
  input  logic                                           b_mm_mispred_i,
  input  logic [B_MASK_WIDTH-1:0]                        next_b_mask_i,
  input  logic [ADDR_WIDTH-1:0]                          entry_pc_i        [B_MASK_WIDTH],
  input  logic [ROB_SZ_BITS-1:0]                         entry_rob_tail_i  [B_MASK_WIDTH],
  input  logic [PHYS_REG_SZ_R10K-1:0]                    entry_free_list_i [B_MASK_WIDTH],
  input  logic [ARCH_REG_SZ_R10K-1:0][PHYS_IDX_BITS-1:0] entry_map_table_i [B_MASK_WIDTH],
  input  logic [B_MASK_WIDTH-1:0]                        entry_b_m_i       [B_MASK_WIDTH],
  output logic [ADDR_WIDTH-1:0]                          pc_restore_o,
  output logic                                           pc_restore_valid_o,
  output logic [ROB_SZ_BITS-1:0]                         rob_tail_restore_o,
  output logic                                           rob_tail_restore_valid_o,
  output logic [PHYS_REG_SZ_R10K-1:0]                    freelist_restore_o,
  output logic                                           freelist_restore_valid_o,
  output logic [ARCH_REG_SZ_R10K-1:0][PHYS_IDX_BITS-1:0] map_table_restore_o,
  output logic                                           map_table_restore_valid_o,
  output logic [B_MASK_WIDTH-1:0]                        b_mask_combinational_o
);
  localparam int KW = (B_MASK_WIDTH > 1) ? $clog2(B_MASK_WIDTH) : 1;

  logic [B_MASK_WIDTH-1:0]                        b_mask_q, b_mask_d;
  logic [ADDR_WIDTH-1:0]                          pc_q  [B_MASK_WIDTH];
  logic [ADDR_WIDTH-1:0]                          pc_d  [B_MASK_WIDTH];
  logic [ROB_SZ_BITS-1:0]                         rob_q [B_MASK_WIDTH];
  logic [ROB_SZ_BITS-1:0]                         rob_d [B_MASK_WIDTH];
  logic [PHYS_REG_SZ_R10K-1:0]                    fl_q  [B_MASK_WIDTH];
  logic [PHYS_REG_SZ_R10K-1:0]                    fl_d  [B_MASK_WIDTH];
  logic [ARCH_REG_SZ_R10K-1:0][PHYS_IDX_BITS-1:0] map_q [B_MASK_WIDTH];
  logic [ARCH_REG_SZ_R10K-1:0][PHYS_IDX_BITS-1:0] map_d [B_MASK_WIDTH];
  logic [B_MASK_WIDTH-1:0]                        b_m_q [B_MASK_WIDTH];
  logic [B_MASK_WIDTH-1:0]                        b_m_d [B_MASK_WIDTH];

  logic [KW-1:0]           k_s;
  logic                    restore_s;
  logic [B_MASK_WIDTH-1:0] squash_s;
  logic [B_MASK_WIDTH-1:0] alloc_s;

  // A mispredict squashes the resolving slot plus every slot that depends on it
  always_comb begin
    k_s       = '0;
    restore_s = (|b_mm_resolve_i) & b_mm_mispred_i & ~reset_i;
    squash_s  = '0;
    for (int i = 0; i < B_MASK_WIDTH; i++) begin
      k_s         = b_mm_resolve_i[i] ? KW'(i) : k_s;
      squash_s[i] = b_mm_resolve_i[i] | (restore_s & (|(b_m_q[i] & b_mm_resolve_i)));
    end
  end

  assign b_mask_combinational_o    = b_mask_q & ~squash_s;
  assign pc_restore_valid_o        = restore_s;
  assign rob_tail_restore_valid_o  = restore_s;
  assign freelist_restore_valid_o  = restore_s;
  assign map_table_restore_valid_o = restore_s;
  assign pc_restore_o              = restore_s ? pc_q[k_s]  : '0;
  assign rob_tail_restore_o        = restore_s ? rob_q[k_s] : '0;
  assign freelist_restore_o        = restore_s ? fl_q[k_s]  : '0;
  assign map_table_restore_o       = restore_s ? map_q[k_s] : '0;

  // A slot freed by this cycle's resolve may be reallocated in the same cycle
  always_comb begin
    b_mask_d = next_b_mask_i;
    alloc_s  = next_b_mask_i & ~b_mask_combinational_o;
    for (int i = 0; i < B_MASK_WIDTH; i++) begin
      pc_d[i]  = alloc_s[i] ? entry_pc_i[i]        : pc_q[i];
      rob_d[i] = alloc_s[i] ? entry_rob_tail_i[i]  : rob_q[i];
      fl_d[i]  = alloc_s[i] ? entry_free_list_i[i] : fl_q[i];
      map_d[i] = alloc_s[i] ? entry_map_table_i[i] : map_q[i];
      b_m_d[i] = (alloc_s[i] ? entry_b_m_i[i] : b_m_q[i]) & ~b_mm_resolve_i;
    end
  end

  // Checkpoint storage with synchronous reset
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      b_mask_q <= '0;
      for (int i = 0; i < B_MASK_WIDTH; i++) begin
        pc_q[i]  <= '0;
        rob_q[i] <= '0;
        fl_q[i]  <= '0;
        map_q[i] <= '0;
        b_m_q[i] <= '0;
      end
    end else begin
      b_mask_q <= b_mask_d;
      for (int i = 0; i < B_MASK_WIDTH; i++) begin
        pc_q[i]  <= pc_d[i];
        rob_q[i] <= rob_d[i];
        fl_q[i]  <= fl_d[i];
        map_q[i] <= map_d[i];
        b_m_q[i] <= b_m_d[i];
      end
    end
  end
endmodule

// File: tb/tb_branch_stack.sv
// Self-checking bench for branch_stack: directed vector table, hand sequences for
// reallocation and mid-run reset, and randomized resolves against a slot-level model.
module tb_branch_stack;
  localparam int B = 4;

  logic             clock_i = 1'b0;
  logic             reset_i;
  logic [B-1:0]     r, nxt;
  logic             mispred;
  logic [31:0]      pc_in  [B];
  logic [4:0]       rob_in [B];
  logic [63:0]      fl_in  [B];
  logic [31:0][5:0] map_in [B];
  logic [B-1:0]     bm_in  [B];
  logic [31:0]      pc_o;
  logic             pc_v, rob_v, fl_v, map_v;
  logic [4:0]       rob_o;
  logic [63:0]      fl_o;
  logic [31:0][5:0] map_o;
  logic [B-1:0]     comb_o;

  always #5 clock_i = ~clock_i;

  branch_stack #(.B_MASK_WIDTH(4), .ROB_SZ_BITS(5), .PHYS_REG_SZ_R10K(64),
                 .ARCH_REG_SZ_R10K(32), .ADDR_WIDTH(32)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .b_mm_resolve_i(r), .b_mm_mispred_i(mispred), .next_b_mask_i(nxt),
    .entry_pc_i(pc_in), .entry_rob_tail_i(rob_in), .entry_free_list_i(fl_in),
    .entry_map_table_i(map_in), .entry_b_m_i(bm_in),
    .pc_restore_o(pc_o), .pc_restore_valid_o(pc_v),
    .rob_tail_restore_o(rob_o), .rob_tail_restore_valid_o(rob_v),
    .freelist_restore_o(fl_o), .freelist_restore_valid_o(fl_v),
    .map_table_restore_o(map_o), .map_table_restore_valid_o(map_v),
    .b_mask_combinational_o(comb_o)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: the set of live checkpoints and what each depends on
  logic [B-1:0]     m_mask = '0;
  logic [31:0]      m_pc  [B];
  logic [4:0]       m_rob [B];
  logic [63:0]      m_fl  [B];
  logic [31:0][5:0] m_map [B];
  logic [B-1:0]     m_dep [B];
  logic [B-1:0]     e_comb, e_kill;
  logic             e_valid;
  logic [31:0]      e_pc;
  logic [4:0]       e_rob;
  logic [63:0]      e_fl;
  logic [31:0][5:0] e_map;

  typedef struct {
    logic [B-1:0] r;
    logic         m;
    logic [B-1:0] nxt;
    logic [B-1:0] exp_comb;
    logic         exp_v;
    logic [31:0]  exp_pc;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_eval();
    int k;
    k = -1;
    for (int i = 0; i < B; i++) if (r[i]) k = i;
    e_valid = (k >= 0) && mispred && !reset_i;
    e_kill = '0;
    if (k >= 0) begin
      e_kill[k] = 1'b1;
      if (e_valid) for (int j = 0; j < B; j++) if (m_dep[j][k]) e_kill[j] = 1'b1;
    end
    e_comb = m_mask & ~e_kill;
    e_pc = '0; e_rob = '0; e_fl = '0; e_map = '0;
    if (e_valid) begin
      e_pc = m_pc[k]; e_rob = m_rob[k]; e_fl = m_fl[k]; e_map = m_map[k];
    end
  endtask

  task automatic model_update();
    if (reset_i) begin
      m_mask = '0;
      for (int i = 0; i < B; i++) begin
        m_pc[i] = '0; m_rob[i] = '0; m_fl[i] = '0; m_map[i] = '0; m_dep[i] = '0;
      end
    end else begin
      for (int i = 0; i < B; i++) begin
        if (nxt[i] && !e_comb[i]) begin
          m_pc[i] = pc_in[i]; m_rob[i] = rob_in[i]; m_fl[i] = fl_in[i];
          m_map[i] = map_in[i]; m_dep[i] = bm_in[i] & ~r;
        end else begin
          m_dep[i] = m_dep[i] & ~r;
        end
      end
      m_mask = nxt;
    end
  endtask

  task automatic check_all();
    chk("comb", 256'(comb_o), 256'(e_comb));
    chk("pc_valid", 256'(pc_v), 256'(e_valid));
    chk("rob_valid", 256'(rob_v), 256'(e_valid));
    chk("fl_valid", 256'(fl_v), 256'(e_valid));
    chk("map_valid", 256'(map_v), 256'(e_valid));
    chk("pc_restore", 256'(pc_o), 256'(e_pc));
    chk("rob_restore", 256'(rob_o), 256'(e_rob));
    chk("fl_restore", 256'(fl_o), 256'(e_fl));
    chk("map_restore", 256'(map_o), 256'(e_map));
  endtask

  // Inputs are stable from the previous negedge; check mid-cycle, then advance
  task automatic tick_begin(input bit do_check);
    model_eval();
    #1;
    if (do_check) check_all();
  endtask

  task automatic tick_end();
    @(posedge clock_i);
    model_update();
    @(negedge clock_i);
  endtask

  task automatic set_chain();
    for (int i = 0; i < B; i++) begin
      pc_in[i]  = 32'h100 * (i + 1);
      rob_in[i] = 5'(i * 3 + 1);
      fl_in[i]  = {32'hF0F0_0000 + 32'(i), 32'h1234_0000 | 32'(i)};
      for (int a = 0; a < 32; a++) map_in[i][a] = 6'((a + i) % 64);
      bm_in[i]  = 4'((1 << i) - 1);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1; r = '0; mispred = 1'b0; nxt = '0;
    tick_begin(1'b0); tick_end();
    tick_begin(1'b0); tick_end();
    reset_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b0, 32'h0};
    vecs[1]  = '{4'b0000, 1'b0, 4'b1111, 4'b1111, 1'b0, 32'h0};
    vecs[2]  = '{4'b0100, 1'b0, 4'b1011, 4'b1011, 1'b0, 32'h0};
    vecs[3]  = '{4'b0000, 1'b0, 4'b1111, 4'b1011, 1'b0, 32'h0};
    vecs[4]  = '{4'b0010, 1'b1, 4'b0001, 4'b0001, 1'b1, 32'h200};
    vecs[5]  = '{4'b0000, 1'b0, 4'b1111, 4'b0001, 1'b0, 32'h0};
    vecs[6]  = '{4'b0010, 1'b1, 4'b0001, 4'b0001, 1'b1, 32'h200};
    vecs[7]  = '{4'b0000, 1'b0, 4'b1111, 4'b0001, 1'b0, 32'h0};
    vecs[8]  = '{4'b0001, 1'b0, 4'b1110, 4'b1110, 1'b0, 32'h0};
    vecs[9]  = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b1, 32'h200};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0};

    set_chain();
    reset_i = 1'b1; r = '0; mispred = 1'b0; nxt = '0;
    @(negedge clock_i);
    do_reset();

    // Post-reset state with idle inputs
    tick_begin(1'b1);
    chk("rst_comb", 256'(comb_o), 256'(4'b0000));
    chk("rst_valids", 256'({pc_v, rob_v, fl_v, map_v}), 256'(4'b0000));
    chk("rst_data", 256'({pc_o, rob_o, fl_o}), 256'(0));
    tick_end();

    for (int v = 0; v < 11; v++) begin
      r = vecs[v].r; mispred = vecs[v].m; nxt = vecs[v].nxt;
      tick_begin(1'b1);
      chk($sformatf("vec%0d_comb", v), 256'(comb_o), 256'(vecs[v].exp_comb));
      chk($sformatf("vec%0d_valid", v), 256'(pc_v), 256'(vecs[v].exp_v));
      chk($sformatf("vec%0d_pc", v), 256'(pc_o), 256'(vecs[v].exp_pc));
      tick_end();
    end

    // Same-cycle reallocation of a slot freed by a correct resolve
    do_reset(); set_chain();
    r = '0; mispred = 1'b0; nxt = 4'b1111;
    tick_begin(1'b1); tick_end();
    r = 4'b0100; pc_in[2] = 32'h500;
    tick_begin(1'b1);
    chk("realloc_comb", 256'(comb_o), 256'(4'b1011));
    tick_end();
    r = '0;
    tick_begin(1'b1);
    chk("realloc_full", 256'(comb_o), 256'(4'b1111));
    tick_end();
    r = 4'b0100; mispred = 1'b1; nxt = 4'b1011;
    tick_begin(1'b1);
    chk("realloc_pc", 256'(pc_o), 256'(32'h500));
    chk("realloc_squash", 256'(comb_o), 256'(4'b1011));
    tick_end();

    // Reset while the stack is full overrides dispatch
    r = '0; mispred = 1'b0; nxt = 4'b1111;
    tick_begin(1'b1); tick_end();
    reset_i = 1'b1;
    tick_begin(1'b0); tick_end();
    reset_i = 1'b0; nxt = '0;
    tick_begin(1'b1);
    chk("midrst_comb", 256'(comb_o), 256'(4'b0000));
    tick_end();

    // Randomized resolves: correct predictions first, then mispredicts
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 100; c++) begin
        int j;
        mispred = 1'(p);
        r = '0;
        if (m_mask != '0 && ($urandom % 5) != 0) begin
          j = int'($urandom % B);
          while (!m_mask[j]) j = (j + 1) % B;
          r[j] = 1'b1;
        end
        model_eval();
        nxt = e_comb | ((($urandom % 4) != 0) ? ~e_comb : 4'($urandom));
        for (int i = 0; i < B; i++) begin
          pc_in[i] = $urandom; rob_in[i] = 5'($urandom); fl_in[i] = {$urandom, $urandom};
          for (int a = 0; a < 32; a++) map_in[i][a] = 6'($urandom);
          bm_in[i] = e_comb;
        end
        tick_begin(1'b1);
        chk("rand_no_freed", 256'(comb_o & e_kill), 256'(0));
        tick_end();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
